id_ctrl_pipe: RTL and testbench

Parametrised, registered successor to the combinational RV32I control decoder in decode_stage.
- Decodes one instruction per cycle into a registered ID/EX control bundle: controls, immediate, register indices.
- Uses valid/ready handshakes on both sides.
- Detects load-use hazards itself and inserts bubbles.
- Supports synchronous flush for branch/jump redirect. One instance per core.

---
 rtl/id_ctrl_pipe.sv | 301 ++++++++++++++++++++++++++++++
 tb/tb_id_ctrl_pipe.sv | 390 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ctrl_pipe.sv
// id_ctrl_pipe: RV32I decode into a registered ID/EX bundle; latency 1, valid/ready on both sides,
// bundle held under backpressure, load-use bubbles inserted locally; `ID_CTRL_MEXT_EN adds M-ext decode.
module id_ctrl_pipe #(
  parameter int XLEN             = 32,
  parameter int LOAD_USE_BUBBLES = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [4:0]      out_rd,
  output logic [XLEN-1:0] out_imm,
  output logic            out_reg_write,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_mem_to_reg,
  output logic            out_alu_src,
  output logic            out_branch,
  output logic            out_jump,
  output logic            out_pc_src_a,
  output logic [2:0]      out_funct3,
  output logic [3:0]      out_alu_ctrl,
  output logic            out_illegal,
  output logic            out_mdu_en,
  output logic [2:0]      out_mdu_op
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_LUI  = 4'hA;
  localparam logic [3:0] ALU_NOP  = 4'hF;

  localparam logic [1:0] BUBBLES = 2'(LOAD_USE_BUBBLES);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            mem_to_reg;
    logic            alu_src;
    logic            branch;
    logic            jump;
    logic            pc_src_a;
    logic [2:0]      funct3;
    logic [3:0]      alu_ctrl;
    logic            illegal;
    logic            mdu_en;
    logic [2:0]      mdu_op;
  } bundle_t;

  typedef enum logic {RUN, STALL} state_t;

  // alt selects SUB (R-type only) and the arithmetic right shift
  function automatic logic [3:0] alu_of(input logic [2:0] f3, input logic alt, input logic is_r);
    case (f3)
      3'd0:    alu_of = (alt && is_r) ? ALU_SUB : ALU_ADD;
      3'd1:    alu_of = ALU_SLL;
      3'd2:    alu_of = ALU_SLT;
      3'd3:    alu_of = ALU_SLTU;
      3'd4:    alu_of = ALU_XOR;
      3'd5:    alu_of = alt ? ALU_SRA : ALU_SRL;
      3'd6:    alu_of = ALU_OR;
      default: alu_of = ALU_AND;
    endcase
  endfunction

  logic [6:0]      opcode;
  logic [6:0]      funct7;
  logic [2:0]      funct3;
  logic [4:0]      f_rs1;
  logic [4:0]      f_rs2;
  logic [4:0]      f_rd;
  logic            alt;
  logic [XLEN-1:0] imm_i;
  logic [XLEN-1:0] imm_s;
  logic [XLEN-1:0] imm_b;
  logic [XLEN-1:0] imm_u;
  logic [XLEN-1:0] imm_j;

  assign opcode = in_instr[6:0];
  assign funct7 = in_instr[31:25];
  assign funct3 = in_instr[14:12];
  assign f_rs1  = in_instr[19:15];
  assign f_rs2  = in_instr[24:20];
  assign f_rd   = in_instr[11:7];
  assign alt    = (funct7 == 7'b0100000);

  assign imm_i = XLEN'($signed(in_instr[31:20]));
  assign imm_s = XLEN'($signed({in_instr[31:25], in_instr[11:7]}));
  assign imm_b = XLEN'($signed({in_instr[31], in_instr[7], in_instr[30:25], in_instr[11:8], 1'b0}));
  assign imm_u = XLEN'($signed({in_instr[31:12], 12'h000}));
  assign imm_j = XLEN'($signed({in_instr[31], in_instr[19:12], in_instr[20], in_instr[30:21], 1'b0}));

  bundle_t dec;

  always_comb begin
    dec          = '0;
    dec.pc       = in_pc;
    dec.funct3   = funct3;
    dec.alu_ctrl = ALU_NOP;
    case (opcode)
      OP_R: begin
        if (funct7 == 7'b0000000 || funct7 == 7'b0100000) begin
          dec.rs1       = f_rs1;
          dec.rs2       = f_rs2;
          dec.rd        = f_rd;
          dec.reg_write = 1'b1;
          dec.alu_ctrl  = alu_of(funct3, alt, 1'b1);
        end
`ifdef ID_CTRL_MEXT_EN
        else if (funct7 == 7'b0000001) begin
          dec.rs1       = f_rs1;
          dec.rs2       = f_rs2;
          dec.rd        = f_rd;
          dec.reg_write = 1'b1;
          dec.mdu_en    = 1'b1;
          dec.mdu_op    = funct3;
        end
`endif
        else begin
          dec.illegal = 1'b1;
        end
      end
      OP_I: begin
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.imm       = imm_i;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = alu_of(funct3, alt, 1'b0);
      end
      OP_LOAD: begin
        dec.rs1        = f_rs1;
        dec.rd         = f_rd;
        dec.imm        = imm_i;
        dec.alu_src    = 1'b1;
        dec.mem_read   = 1'b1;
        dec.mem_to_reg = 1'b1;
        dec.reg_write  = 1'b1;
        dec.alu_ctrl   = ALU_ADD;
      end
      OP_STORE: begin
        dec.rs1       = f_rs1;
        dec.rs2       = f_rs2;
        dec.imm       = imm_s;
        dec.alu_src   = 1'b1;
        dec.mem_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_BRANCH: begin
        dec.rs1      = f_rs1;
        dec.rs2      = f_rs2;
        dec.imm      = imm_b;
        dec.branch   = 1'b1;
        dec.alu_ctrl = ALU_SUB;
      end
      OP_JAL: begin
        dec.rd        = f_rd;
        dec.imm       = imm_j;
        dec.jump      = 1'b1;
        dec.pc_src_a  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_JALR: begin
        dec.rs1       = f_rs1;
        dec.rd        = f_rd;
        dec.imm       = imm_i;
        dec.jump      = 1'b1;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      OP_LUI: begin
        dec.rd        = f_rd;
        dec.imm       = imm_u;
        dec.alu_src   = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_LUI;
      end
      OP_AUIPC: begin
        dec.rd        = f_rd;
        dec.imm       = imm_u;
        dec.alu_src   = 1'b1;
        dec.pc_src_a  = 1'b1;
        dec.reg_write = 1'b1;
        dec.alu_ctrl  = ALU_ADD;
      end
      default: dec.illegal = 1'b1;
    endcase
  end

  state_t     state;
  logic       valid_q;
  bundle_t    held;
  logic [1:0] cnt;
  logic [4:0] load_rd;

  logic       accept;
  logic       xfer;
  logic       opens;
  logic       valid_nxt;
  logic [1:0] cnt_nxt;
  logic [4:0] load_rd_nxt;
  logic [4:0] rs1_nxt;
  logic [4:0] rs2_nxt;
  logic       hazard_nxt;

  assign out_valid = valid_q && (state == RUN);
  assign in_ready  = (!valid_q || out_ready) && !flush && (state == RUN);
  assign accept    = in_valid && in_ready;
  assign xfer      = out_valid && out_ready && !flush;
  assign opens     = xfer && held.mem_read && (held.rd != 5'd0) && (BUBBLES != 2'd0);

  assign valid_nxt   = accept ? 1'b1 : (xfer ? 1'b0 : valid_q);
  assign cnt_nxt     = opens ? BUBBLES : ((cnt != 2'd0) ? cnt - 2'd1 : 2'd0);
  assign load_rd_nxt = opens ? held.rd : load_rd;
  assign rs1_nxt     = accept ? dec.rs1 : held.rs1;
  assign rs2_nxt     = accept ? dec.rs2 : held.rs2;

  // Stall is decided one edge early so in_ready and out_valid come straight from flops.
  assign hazard_nxt = valid_nxt && (cnt_nxt != 2'd0) && (load_rd_nxt != 5'd0) &&
                      ((rs1_nxt == load_rd_nxt) || (rs2_nxt == load_rd_nxt));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= RUN;
      valid_q       <= 1'b0;
      cnt           <= 2'd0;
      load_rd       <= 5'd0;
      held          <= '0;
      held.alu_ctrl <= ALU_NOP;
    end else if (flush) begin
      state   <= RUN;
      valid_q <= 1'b0;
      cnt     <= 2'd0;
    end else begin
      valid_q <= valid_nxt;
      cnt     <= cnt_nxt;
      load_rd <= load_rd_nxt;
      state   <= hazard_nxt ? STALL : RUN;
      if (accept) held <= dec;
    end
  end

  assign out_pc         = held.pc;
  assign out_rs1        = held.rs1;
  assign out_rs2        = held.rs2;
  assign out_rd         = held.rd;
  assign out_imm        = held.imm;
  assign out_reg_write  = held.reg_write;
  assign out_mem_read   = held.mem_read;
  assign out_mem_write  = held.mem_write;
  assign out_mem_to_reg = held.mem_to_reg;
  assign out_alu_src    = held.alu_src;
  assign out_branch     = held.branch;
  assign out_jump       = held.jump;
  assign out_pc_src_a   = held.pc_src_a;
  assign out_funct3     = held.funct3;
  assign out_alu_ctrl   = held.alu_ctrl;
  assign out_illegal    = held.illegal;
`ifdef ID_CTRL_MEXT_EN
  assign out_mdu_en     = held.mdu_en;
  assign out_mdu_op     = held.mdu_op;
`else
  assign out_mdu_en     = 1'b0;
  assign out_mdu_op     = 3'd0;
`endif

endmodule

// File: tb/tb_id_ctrl_pipe.sv
// Bench for id_ctrl_pipe: directed literal cases, then randomized traffic against a
// cycle-indexed reference of decode, handshake, load-use visibility and flush.
module tb_id_ctrl_pipe;
  localparam int XLEN = 32;
  localparam int B    = 1;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [31:0]     in_instr = '0;
  logic [XLEN-1:0] in_pc = '0;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [XLEN-1:0] out_pc;
  logic [4:0]      out_rs1, out_rs2, out_rd;
  logic [XLEN-1:0] out_imm;
  logic            out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg;
  logic            out_alu_src, out_branch, out_jump, out_pc_src_a;
  logic [2:0]      out_funct3;
  logic [3:0]      out_alu_ctrl;
  logic            out_illegal, out_mdu_en;
  logic [2:0]      out_mdu_op;

  always #5 clk = ~clk;

  id_ctrl_pipe #(.XLEN(XLEN), .LOAD_USE_BUBBLES(B)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read), .out_mem_write(out_mem_write),
    .out_mem_to_reg(out_mem_to_reg), .out_alu_src(out_alu_src), .out_branch(out_branch),
    .out_jump(out_jump), .out_pc_src_a(out_pc_src_a), .out_funct3(out_funct3),
    .out_alu_ctrl(out_alu_ctrl), .out_illegal(out_illegal), .out_mdu_en(out_mdu_en),
    .out_mdu_op(out_mdu_op)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [31:0] pc, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        rw, mr, mw, m2r, asrc, br, jmp, pca, ill, mdu;
    logic [2:0]  f3, mop;
    logic [3:0]  alu;
  } exp_t;

  // ALU code for an arithmetic funct3; sub_ok marks R-type where funct7 picks SUB
  function automatic logic [3:0] ref_alu(input logic [2:0] f3, input logic alt, input bit sub_ok);
    logic [3:0] code;
    case (f3)
      3'd0: code = (alt && sub_ok) ? 4'h1 : 4'h0;
      3'd1: code = 4'h5;
      3'd2: code = 4'h8;
      3'd3: code = 4'h9;
      3'd4: code = 4'h4;
      3'd5: code = alt ? 4'h7 : 4'h6;
      3'd6: code = 4'h3;
      default: code = 4'h2;
    endcase
    return code;
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc);
    exp_t e;
    int ii, ss, bb, jj, uu;
    logic [6:0] f7;
    f7 = w[31:25];
    ii = (w[31] ? -2048 : 0) + int'(w[30:20]);
    ss = (w[31] ? -2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:7]);
    bb = (w[31] ? -4096 : 0) + int'(w[7]) * 2048 + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    jj = (w[31] ? -(1 << 20) : 0) + int'(w[19:12]) * 4096 + int'(w[20]) * 2048 + int'(w[30:21]) * 2;
    uu = int'(w[31:12]) << 12;
    e = '{pc: pc, imm: 32'h0, rs1: 5'd0, rs2: 5'd0, rd: 5'd0, rw: 0, mr: 0, mw: 0, m2r: 0,
          asrc: 0, br: 0, jmp: 0, pca: 0, ill: 0, mdu: 0, f3: w[14:12], mop: 3'd0, alu: 4'hF};
    case (w[6:0])
      7'h33: begin
        if (f7 == 7'h00 || f7 == 7'h20) begin
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.rw = 1;
          e.alu = ref_alu(w[14:12], f7 == 7'h20, 1);
        end
`ifdef ID_CTRL_MEXT_EN
        else if (f7 == 7'h01) begin
          e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.rd = w[11:7]; e.rw = 1;
          e.mdu = 1; e.mop = w[14:12];
        end
`endif
        else e.ill = 1;
      end
      7'h13: begin
        e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(ii); e.rw = 1; e.asrc = 1;
        e.alu = ref_alu(w[14:12], f7 == 7'h20, 0);
      end
      7'h03: begin
        e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(ii); e.rw = 1; e.asrc = 1;
        e.mr = 1; e.m2r = 1; e.alu = 4'h0;
      end
      7'h23: begin
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'(ss); e.asrc = 1; e.mw = 1; e.alu = 4'h0;
      end
      7'h63: begin
        e.rs1 = w[19:15]; e.rs2 = w[24:20]; e.imm = 32'(bb); e.br = 1; e.alu = 4'h1;
      end
      7'h6F: begin
        e.rd = w[11:7]; e.imm = 32'(jj); e.jmp = 1; e.pca = 1; e.rw = 1; e.alu = 4'h0;
      end
      7'h67: begin
        e.rs1 = w[19:15]; e.rd = w[11:7]; e.imm = 32'(ii); e.jmp = 1; e.asrc = 1; e.rw = 1;
        e.alu = 4'h0;
      end
      7'h37: begin
        e.rd = w[11:7]; e.imm = 32'(uu); e.rw = 1; e.asrc = 1; e.alu = 4'hA;
      end
      7'h17: begin
        e.rd = w[11:7]; e.imm = 32'(uu); e.rw = 1; e.asrc = 1; e.pca = 1; e.alu = 4'h0;
      end
      default: e.ill = 1;
    endcase
    return e;
  endfunction

  // Reference: one held bundle, visible from cycle 'vis'; a bundle depending on a load
  // that handed off at cycle load_cyc stays hidden until cycle load_cyc + B + 1.
  exp_t        slot;
  bit          slot_full = 0;
  longint      vis = 0;
  bit          win = 0;
  longint      load_cyc = 0;
  logic [4:0]  load_rd = 0;
  longint      cyc = 0;
  bit          ev, er, xfer, acc;

  always @(negedge clk) begin
    if (rst) begin
      slot_full = 0;
      win = 0;
    end else begin
      ev = slot_full && (cyc >= vis);
      er = (!slot_full || (ev && out_ready)) && !flush;
      chk("out_valid", out_valid, ev);
      chk("in_ready", in_ready, er);
      if (ev) begin
        chk("pc", out_pc, slot.pc);           chk("rs1", out_rs1, slot.rs1);
        chk("rs2", out_rs2, slot.rs2);        chk("rd", out_rd, slot.rd);
        chk("imm", out_imm, slot.imm);        chk("reg_write", out_reg_write, slot.rw);
        chk("mem_read", out_mem_read, slot.mr);
        chk("mem_write", out_mem_write, slot.mw);
        chk("mem_to_reg", out_mem_to_reg, slot.m2r);
        chk("alu_src", out_alu_src, slot.asrc);
        chk("branch", out_branch, slot.br);   chk("jump", out_jump, slot.jmp);
        chk("pc_src_a", out_pc_src_a, slot.pca);
        chk("funct3", out_funct3, slot.f3);   chk("alu_ctrl", out_alu_ctrl, slot.alu);
        chk("illegal", out_illegal, slot.ill);
        chk("mdu_en", out_mdu_en, slot.mdu);  chk("mdu_op", out_mdu_op, slot.mop);
      end
      if (flush) begin
        slot_full = 0;
        win = 0;
      end else begin
        xfer = ev && out_ready;
        acc  = in_valid && er;
        if (xfer && slot.mr && slot.rd != 5'd0 && B > 0) begin
          win = 1; load_cyc = cyc; load_rd = slot.rd;
        end
        if (acc) begin
          slot = ref_decode(in_instr, in_pc);
          slot_full = 1;
          vis = cyc + 1;
          if (win && (slot.rs1 == load_rd || slot.rs2 == load_rd) && (cyc + 1 <= load_cyc + B))
            vis = load_cyc + B + 1;
        end else if (xfer) begin
          slot_full = 0;
        end
      end
    end
    cyc++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // lw x2,0(x1) followed back-to-back by 'second'; n = hidden cycles before 'second' shows
  task automatic measure(input logic [31:0] second, output int n);
    in_valid = 0;
    tick(); tick();
    in_valid = 1; in_instr = 32'h0000A103; in_pc = 32'h200;
    tick();
    in_instr = second; in_pc = 32'h204;
    tick();
    in_valid = 0;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (out_valid) break;
      n++;
    end
    chk("second_rd", out_rd, 5'd3);
    tick();
  endtask

  function automatic logic [31:0] rnd_instr();
    logic [4:0]  r1 = 5'($urandom_range(0, 3));
    logic [4:0]  r2 = 5'($urandom_range(0, 3));
    logic [4:0]  rd = 5'($urandom_range(0, 3));
    logic [2:0]  f3 = 3'($urandom);
    logic [6:0]  f7;
    logic [11:0] im = 12'($urandom);
    case ($urandom_range(0, 3))
      0: f7 = 7'h00;
      1: f7 = 7'h20;
      2: f7 = 7'h01;
      default: f7 = 7'($urandom);
    endcase
    if ($urandom_range(0, 1) == 1) im[11:5] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    case ($urandom_range(0, 11))
      0, 1:    return {f7, r2, r1, f3, rd, 7'h33};
      2:       return {im, r1, f3, rd, 7'h13};
      3, 4:    return {im, r1, f3, rd, 7'h03};
      5:       return {im[11:5], r2, r1, f3, im[4:0], 7'h23};
      6:       return {im[11:5], r2, r1, f3, im[4:0], 7'h63};
      7:       return {20'($urandom), rd, 7'h6F};
      8:       return {im, r1, 3'd0, rd, 7'h67};
      9:       return {20'($urandom), rd, 7'h37};
      10:      return {20'($urandom), rd, 7'h17};
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int n;
    bit taken;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_alu_ctrl", out_alu_ctrl, 4'hF);
    chk("rst_reg_write", out_reg_write, 1'b0);
    chk("rst_imm", out_imm, 32'h0);
    chk("rst_illegal", out_illegal, 1'b0);
    tick();
    rst = 0;

    // addi x1,x0,5
    tick();
    in_valid = 1; in_instr = 32'h00500093; in_pc = 32'h100;
    @(negedge clk);
    chk("addi_accept_ready", in_ready, 1'b1);
    chk("addi_not_yet_valid", out_valid, 1'b0);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("addi_valid", out_valid, 1'b1);
    chk("addi_rd", out_rd, 5'd1);
    chk("addi_rs1", out_rs1, 5'd0);
    chk("addi_imm", out_imm, 32'd5);
    chk("addi_alu", out_alu_ctrl, 4'h0);
    chk("addi_alu_src", out_alu_src, 1'b1);
    chk("addi_reg_write", out_reg_write, 1'b1);
    tick();

    // sub x3,x1,x2 held under backpressure
    out_ready = 0; in_valid = 1; in_instr = 32'h402081B3; in_pc = 32'h104;
    tick();
    in_valid = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("sub_hold_valid", out_valid, 1'b1);
      chk("sub_hold_alu", out_alu_ctrl, 4'h1);
      chk("sub_hold_in_ready", in_ready, 1'b0);
      tick();
    end
    out_ready = 1;
    @(negedge clk);
    chk("sub_release_in_ready", in_ready, 1'b1);
    tick();
    @(negedge clk);
    chk("sub_gone", out_valid, 1'b0);
    tick();

    // load-use: dependent add gets one bubble, independent add none
    measure(32'h001101B3, n);
    chk("bubble_dependent", n, 1);
    measure(32'h001081B3, n);
    chk("bubble_independent", n, 0);

    // asynchronous reset while a dependent add is stalled
    tick();
    in_valid = 1; in_instr = 32'h0000A103;
    tick();
    in_instr = 32'h001101B3;
    tick();
    in_valid = 0;
    chk("stall_hidden", out_valid, 1'b0);
    chk("stall_in_ready", in_ready, 1'b0);
    #2 rst = 1;
    #1;
    chk("async_rst_valid", out_valid, 1'b0);
    chk("async_rst_alu", out_alu_ctrl, 4'hF);
    chk("async_rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    tick();
    rst = 0;

    // flush with a pending bundle and a new offer
    tick();
    out_ready = 0; in_valid = 1; in_instr = 32'h00500093;
    tick();
    in_instr = 32'h123452B7; flush = 1;
    @(negedge clk);
    chk("flush_in_ready", in_ready, 1'b0);
    chk("flush_pending_valid", out_valid, 1'b1);
    tick();
    flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_cleared", out_valid, 1'b0);
    tick();
    @(negedge clk);
    chk("flush_offer_dropped", out_valid, 1'b0);
    tick();
    out_ready = 1;

    // illegal word then lui x5,0x12345, back to back
    in_valid = 1; in_instr = 32'hFFFFFFFF;
    tick();
    in_instr = 32'h123452B7;
    @(negedge clk);
    chk("ill_valid", out_valid, 1'b1);
    chk("ill_flag", out_illegal, 1'b1);
    chk("ill_reg_write", out_reg_write, 1'b0);
    chk("ill_alu", out_alu_ctrl, 4'hF);
    tick();
    in_valid = 0;
    @(negedge clk);
    chk("lui_imm", out_imm, 32'h12345000);
    chk("lui_alu", out_alu_ctrl, 4'hA);
    chk("lui_rd", out_rd, 5'd5);
    chk("lui_illegal", out_illegal, 1'b0);
    tick();

    // mul x3,x1,x2
    in_valid = 1; in_instr = 32'h022081B3;
    tick();
    in_valid = 0;
    @(negedge clk);
`ifdef ID_CTRL_MEXT_EN
    chk("mul_mdu_en", out_mdu_en, 1'b1);
    chk("mul_mdu_op", out_mdu_op, 3'd0);
    chk("mul_illegal", out_illegal, 1'b0);
    chk("mul_reg_write", out_reg_write, 1'b1);
`else
    chk("mul_mdu_en", out_mdu_en, 1'b0);
    chk("mul_illegal", out_illegal, 1'b1);
    chk("mul_reg_write", out_reg_write, 1'b0);
`endif
    tick();

    // randomized traffic; an unaccepted offer is held until taken
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      taken = in_valid && in_ready;
      tick();
      if (taken || !in_valid) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_instr = rnd_instr();
        in_pc    = {$urandom, 2'b00};
      end
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
    end
    in_valid = 0; flush = 0; out_ready = 1;
    repeat (6) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
